// File: rtl/i2s_audio_tx_pkg.sv
// Shared constants for the I2S transmit path plus the sample-to-wire conversion.
// Optional feature macro: I2S_SIGN_CONVERT_EN (offset binary -> two's complement at load).
package i2s_audio_tx_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int SAMPLE_W        = 16;
  localparam int FRAME_W         = 2 * SAMPLE_W;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  // Clock ratios: MCLK = clk/4, SCK = clk/32, frame = 1024 clk (32 SCK per frame).
  localparam int MCLK_BIT_DEF = 1;
  localparam int SCK_BIT_DEF  = 4;
  localparam int LRCK_BIT_DEF = 9;

  function automatic logic [SAMPLE_W-1:0] to_wire(input logic [SAMPLE_W-1:0] s);
`ifdef I2S_SIGN_CONVERT_EN
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`else
    return s;
`endif
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Free-running DAC clock divider; every DAC clock is a raw counter bit.
// Also provides the slot strobe (cycle before SCK falls) and the frame strobe.
module i2s_clk_div
  import i2s_audio_tx_pkg::*;
#(
  parameter int MCLK_BIT = MCLK_BIT_DEF,
  parameter int SCK_BIT  = SCK_BIT_DEF,
  parameter int LRCK_BIT = LRCK_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_mclk,
  output logic o_sck,
  output logic o_lrck,
  output logic o_slot_evt,
  output logic o_frame_evt
);

  logic [LRCK_BIT:0] r_cnt;

  // Divider counter, wraps naturally from all-ones to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{LRCK_BIT{1'b0}}, 1'b1};
    end
  end

  assign o_mclk      = r_cnt[MCLK_BIT];
  assign o_sck       = r_cnt[SCK_BIT];
  assign o_lrck      = r_cnt[LRCK_BIT];
  assign o_slot_evt  = &r_cnt[SCK_BIT:0];
  assign o_frame_evt = &r_cnt;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-pair holding register behind valid/ready, 32-bit frame shifter.
// Optional feature macro: I2S_SIGN_CONVERT_EN (see i2s_audio_tx_pkg::to_wire).
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int MCLK_BIT = MCLK_BIT_DEF,
  parameter int SCK_BIT  = SCK_BIT_DEF,
  parameter int LRCK_BIT = LRCK_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                frame_start,
  output logic                underrun
);

  logic w_slot_evt;
  logic w_frame_evt;
  logic w_capture;
  logic [SAMPLE_W-1:0] w_load_l;
  logic [SAMPLE_W-1:0] w_load_r;

  logic [FRAME_W-1:0]  r_shreg;
  logic [SAMPLE_W-1:0] r_pend_l;
  logic [SAMPLE_W-1:0] r_pend_r;
  logic [SAMPLE_W-1:0] r_last_l;
  logic [SAMPLE_W-1:0] r_last_r;
  logic                r_pend_full;
  logic                r_sdin;
  logic                r_frame_start;
  logic                r_underrun;

  i2s_clk_div #(
    .MCLK_BIT (MCLK_BIT),
    .SCK_BIT  (SCK_BIT),
    .LRCK_BIT (LRCK_BIT)
  ) u_clk_div (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_mclk      (audio_mclk),
    .o_sck       (audio_sck),
    .o_lrck      (audio_lrck),
    .o_slot_evt  (w_slot_evt),
    .o_frame_evt (w_frame_evt)
  );

  // Ready is low while full, so a capture can never coincide with a frame consume.
  assign sample_ready = !r_pend_full;
  assign w_capture    = sample_valid && !r_pend_full;

  // Frame load source: fresh pair if one is waiting, otherwise repeat the last pair.
  always_comb begin
    if (r_pend_full) begin
      w_load_l = r_pend_l;
      w_load_r = r_pend_r;
    end else begin
      w_load_l = r_last_l;
      w_load_r = r_last_r;
    end
  end

  // Holding register and last-transmitted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      r_pend_l    <= MIDSCALE;
      r_pend_r    <= MIDSCALE;
      r_last_l    <= MIDSCALE;
      r_last_r    <= MIDSCALE;
    end else if (w_capture) begin
      r_pend_l    <= sample_left;
      r_pend_r    <= sample_right;
      r_pend_full <= 1'b1;
    end else if (w_frame_evt && r_pend_full) begin
      r_last_l    <= r_pend_l;
      r_last_r    <= r_pend_r;
      r_pend_full <= 1'b0;
    end
  end

  // Frame shifter: sdin lags the shifter by one slot, which yields the I2S one-SCK delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg       <= {to_wire(MIDSCALE), to_wire(MIDSCALE)};
      r_sdin        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_frame_evt;
      r_underrun    <= w_frame_evt && !r_pend_full;
      if (w_slot_evt) begin
        r_sdin <= r_shreg[FRAME_W-1];
        if (w_frame_evt) begin
          r_shreg <= {to_wire(w_load_l), to_wire(w_load_r)};
        end else begin
          r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  assign audio_sdin  = r_sdin;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: drivers push captured pairs, a negedge monitor
// predicts frame loads and compares the reassembled 32-bit serial word per frame.
module tb_i2s_audio_tx;

  typedef struct packed {
    logic [31:0] w;
    int          tag;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_left = 16'h0000;
  logic [15:0] sample_right = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready, audio_mclk, audio_lrck, audio_sck, audio_sdin;
  logic        frame_start, underrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [9:0] m_cnt = 10'd0;
  logic rst_q = 1'b0;

  cap_t        cap_q[$];
  logic [31:0] word_q[$];
  logic [31:0] m_last;
  logic [31:0] rx;
  logic        rx_on = 1'b0;
  logic        fs_exp = 1'b0;
  logic        ur_exp = 1'b0;

  i2s_audio_tx dut (
    .clk          (clk),
    .rst          (rst),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .audio_sdin   (audio_sdin),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_SIGN_CONVERT_EN
    return {l ^ 16'h8000, r ^ 16'h8000};
`else
    return {l, r};
`endif
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d cnt %0d: got %b, expected %b", nm, cyc, m_cnt, act, exp);
    end
  endtask

  // Reference cycle counter: tracks what the divider should hold.
  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      m_cnt <= 10'd0;
      cyc   <= 0;
    end else begin
      m_cnt <= m_cnt + 10'd1;
      cyc   <= cyc + 1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic pend;
    cap_t c;
    if (rst) begin
      if (rst_q) begin
        check1("rst_sdin", audio_sdin, 1'b0);
        check1("rst_frame_start", frame_start, 1'b0);
        check1("rst_underrun", underrun, 1'b0);
        check1("rst_clocks", audio_mclk | audio_sck | audio_lrck, 1'b0);
        check1("rst_ready", sample_ready, 1'b1);
      end
      cap_q.delete();
      word_q.delete();
      word_q.push_back(exp_word(16'h8000, 16'h8000));
      m_last = {16'h8000, 16'h8000};
      rx_on  = 1'b0;
      fs_exp = 1'b0;
      ur_exp = 1'b0;
    end else begin
      check1("mclk", audio_mclk, m_cnt[1]);
      check1("sck", audio_sck, m_cnt[4]);
      check1("lrck", audio_lrck, m_cnt[9]);
      pend = (cap_q.size() > 0) && (cap_q[0].tag < cyc);
      check1("ready", sample_ready, !pend);
      check1("frame_start", frame_start, fs_exp);
      check1("underrun", underrun, ur_exp);
      fs_exp = 1'b0;
      ur_exp = 1'b0;
      if (m_cnt[4:0] == 5'd16) begin
        if (m_cnt[9:5] == 5'd1) begin
          rx_on = (word_q.size() > 0);
          rx    = {31'd0, audio_sdin};
        end else begin
          rx = {rx[30:0], audio_sdin};
          if (m_cnt[9:5] == 5'd0 && rx_on) begin
            check32("frame_word", rx, word_q.pop_front());
            rx_on = 1'b0;
          end
        end
      end
      if (m_cnt == 10'h3FF) begin
        if (pend) begin
          c = cap_q.pop_front();
          m_last = c.w;
        end else begin
          ur_exp = 1'b1;
        end
        fs_exp = 1'b1;
        word_q.push_back(exp_word(m_last[31:16], m_last[15:0]));
      end
    end
  end

  // Called at a negedge: hold the pair valid until accepted (bounded wait).
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int i = 0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    while (!sample_ready && i < 3000) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (sample_ready) begin
      cap_q.push_back('{w: {l, r}, tag: cyc});
    end else begin
      n_err++;
      $display("FAIL send_timeout: ready still %b after %0d cycles, required 1", sample_ready, i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Called at a negedge: valid held high with fresh data every cycle.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      sample_left  = 16'h1000 + 16'(i);
      sample_right = 16'hE000 - 16'(i);
      sample_valid = 1'b1;
      if (sample_ready) cap_q.push_back('{w: {sample_left, sample_right}, tag: cyc});
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    while (cyc != 5) @(negedge clk);
    send(16'hF530, 16'h8FA0);
    // First load plus two underrun frames repeating the pair.
    repeat (3 * 1024) @(negedge clk);
    stream(3100);
    repeat (2100) @(negedge clk);
    // Valid raised in the frame-event cycle.
    while (m_cnt != 10'h3FF) @(negedge clk);
    send(16'h1234, 16'hABCD);
    repeat (2200) @(negedge clk);
    // Pending pair then reset mid-frame: both must be discarded.
    while (m_cnt != 10'd200) @(negedge clk);
    send(16'h4321, 16'h5678);
    while (m_cnt != 10'd300) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2200) @(negedge clk);
    send(16'h8000 + 16'd30000, 16'h0001);
    repeat (2200) @(negedge clk);
    check1("scoreboard_drained", word_q.size() <= 2, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
